mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory.
//  The data memory has no byte enables, so sub-word stores are done as a read-modify-write.
//  Word stores are a single write.
//  Loads are extracted and sign/zero-extended, then registered into the MEM/WB result.
//  While an RMW is in progress the unit raises stall to the hazard unit.
// PARAMETERS
//  ADDR_W   32   byte-address width of req_addr / dm_A
//  RD_W     5    destination-register index width
// PORTS
//  clk           in   1       pipeline clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  req_valid     in   1       load/store request present this cycle
//  req_we        in   1       1 = store, 0 = load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 treated as word
//  req_unsigned  in   1       1 = zero-extend load (lbu/lhu)
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data; low byte/half used for sb/sh
//  req_rd        in   RD_W    load destination register
//  stall         out  1       hold EX/MEM and earlier stages this cycle (combinational)
//  dm_WE         out  1       data-memory write enable
//  dm_A          out  ADDR_W  data-memory address, always word aligned ([1:0]=00)
//  dm_WD         out  32      data-memory write data
//  dm_RD         in   32      data-memory combinational read data
//  wb_valid      out  1       registered: load result valid for writeback
//  wb_data       out  32      registered: extended load data
//  wb_rd         out  RD_W    registered: load destination
//  misalign      out  1       registered misaligned-access flag (MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  - Reset (async): state IDLE; wb_valid, wb_data, wb_rd, misalign, merge buffer = 0. dm_WE is gated to 0 whenever rst=1.
//  - FSM states:
//    - IDLE:
//      - word store: dm_WE=1, dm_WD=req_wdata, stall=0; stay in IDLE.
//      - sub-word store: dm_WE=0, stall=1; latch aligned address; merge req_wdata into dm_RD at lane addr[1:0]; -> RMW_WR.
//    - RMW_WR: dm_A=latched address, dm_WD=merged word, dm_WE=1, stall=0; req_* ignored; -> IDLE.
//      Upstream holds the store during the stalled cycle and retires it at the end of RMW_WR.
//  - Lane rules (little-endian):
//    - byte: lane = addr[1:0].
//    - half: addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16.
//  - Loads (IDLE only): dm_A=aligned addr; lane extracted from dm_RD; sign-extended unless req_unsigned.
//    Result is registered at the next edge with wb_valid=1 for exactly one cycle: load latency 1, never stalls.
//  - wb_valid=0 for stores, idle cycles, and loads with req_rd=0.
//    wb_data/wb_rd hold their last value when wb_valid=0.
//  - No request accepted in RMW_WR; back-to-back sub-word stores cost 2 cycles each.
//  - Reset mid-RMW aborts the op: no write happens and the memory word is unchanged.
//  - Misalignment means half with addr[0]=1, or word with addr[1:0]!=0.
// CONFIGURATION
//  MISALIGN_TRAP_EN:
//  - Defined: a misaligned request is suppressed: no write, no wb_valid, stall=0.
//    misalign=1 for one cycle after the request; otherwise misalign=0.
//  - Undefined: low address bits below the access size are ignored (access forced aligned).
//    The misalign port is tied to 0.
// TESTING
//  1. After reset, sw 0xDEADBEEF @0x10 then lw @0x10 rd=5:
//     - stall stays 0.
//     - 1 cycle after the lw: wb_valid=1, wb_data=0xDEADBEEF, wb_rd=5.
//  2. Word @0x20=0x11223344, sb 0xAA @0x21:
//     - stall=1 for one cycle, then the word becomes 0x1122AA44.
//     - lb @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA.
//  3. sh 0x8001 @0x22 on 0x1122AA44:
//     - word becomes 0x8001AA44.
//     - lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001.
//  4. rst pulsed during the RMW_WR cycle of sb 0x55 @0x20:
//     - dm_WE stays 0 and the word is unchanged.
//     - wb_valid=0 and the next request is accepted in IDLE.
//  5. lw @0x10 with rd=0 -> wb_valid stays 0. sw @0x14 -> wb_valid stays 0.
//  6. lw @0x13:
//     - macro off: reads the word @0x10.
//     - macro on: misalign=1 next cycle, wb_valid=0.
//     - sw @0x13 with macro on: no write occurs.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word stores direct, sub-word stores via read-modify-write.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              stall,
  output logic              dm_WE,
  output logic [ADDR_W-1:0] dm_A,
  output logic [31:0]       dm_WD,
  input  logic [31:0]       dm_RD,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              misalign
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         merge_q, merge_d;
  logic                wb_valid_q, wb_valid_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                mis;
  logic                we_c;
  logic                size_word, size_half;
  logic [1:0]          lane;
  logic [ADDR_W-1:0]   aligned;
  logic [31:0]         merged;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

  assign size_word = req_size[1];
  assign size_half = (req_size == 2'b01);
  assign aligned   = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign mis = req_valid & ((size_half & req_addr[0]) | (size_word & (req_addr[1:0] != 2'b00)));
  assign misalign = misalign_q;
`else
  assign mis = 1'b0;
  assign misalign = 1'b0;
`endif

  // Misaligned low bits are dropped so the access behaves as if aligned.
  always_comb begin
    lane = req_addr[1:0];
    if (size_word) begin
      lane = 2'b00;
    end else if (size_half) begin
      lane = {req_addr[1], 1'b0};
    end
  end

  always_comb begin
    merged = dm_RD;
    if (size_half) begin
      if (lane[1]) merged[31:16] = req_wdata[15:0];
      else         merged[15:0]  = req_wdata[15:0];
    end else begin
      unique case (lane)
        2'd0: merged[7:0]   = req_wdata[7:0];
        2'd1: merged[15:8]  = req_wdata[7:0];
        2'd2: merged[23:16] = req_wdata[7:0];
        2'd3: merged[31:24] = req_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    unique case (lane)
      2'd0: ld_byte = dm_RD[7:0];
      2'd1: ld_byte = dm_RD[15:8];
      2'd2: ld_byte = dm_RD[23:16];
      2'd3: ld_byte = dm_RD[31:24];
    endcase
    ld_half = lane[1] ? dm_RD[31:16] : dm_RD[15:0];
    if (size_word) begin
      ld_ext = dm_RD;
    end else if (size_half) begin
      ld_ext = req_unsigned ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
    end else begin
      ld_ext = req_unsigned ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    merge_d    = merge_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    stall      = 1'b0;
    we_c       = 1'b0;
    dm_A       = aligned;
    dm_WD      = req_wdata;
`ifdef MISALIGN_TRAP_EN
    misalign_d = mis;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid && !mis) begin
          if (req_we) begin
            if (size_word) begin
              we_c = 1'b1;
            end else begin
              stall   = 1'b1;
              addr_d  = aligned;
              merge_d = merged;
              state_d = StRmwWr;
            end
          end else if (req_rd != '0) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ld_ext;
            wb_rd_d    = req_rd;
          end
        end
      end
      StRmwWr: begin
        dm_A    = addr_q;
        dm_WD   = merge_q;
        we_c    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating by rst keeps a reset that lands in the write cycle from corrupting memory.
  assign dm_WE = we_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      merge_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      merge_q    <= merge_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`endif

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a word-array model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, dm_WE, wb_valid, misalign;
  logic [31:0] dm_A, dm_WD, dm_RD, wb_data;
  logic [4:0]  wb_rd;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        exp_v;
  logic [31:0] exp_d;
  logic [4:0]  exp_rd;
  int          errors = 0;
  int          checks = 0;

  mem_access_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .dm_WE(dm_WE), .dm_A(dm_A), .dm_WD(dm_WD), .dm_RD(dm_RD),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign(misalign)
  );

  always #5 clk = ~clk;

  assign dm_RD = mem[dm_A[7:2]];
  always @(posedge clk) if (dm_WE) mem[dm_A[7:2]] <= dm_WD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic int unsigned byte_off(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return a % 4;
    if (sz == 2'd1) return ((a % 4) >= 2) ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns, input logic [31:0] a);
    int unsigned off = byte_off(sz, a);
    logic [31:0] v;
    if (sz >= 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_val(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [31:0] a, input logic [31:0] wd);
    int unsigned off = byte_off(sz, a);
    logic [31:0] mask;
    if (sz >= 2'd2) return wd;
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Starts and ends on a negative edge with the request bus idle afterwards.
  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bit          bad = ref_mis(sz, a);
    bit          rmw = we && sz < 2 && !bad;
    int          idx = a[7:2];
    logic [31:0] nw = ref_mem[idx];
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
    #1;
    check("stall", {31'd0, stall}, {31'd0, rmw});
    check("dm_we", {31'd0, dm_WE}, {31'd0, we && sz >= 2 && !bad});
    if (!bad) check("dm_a", dm_A, {a[31:2], 2'b00});
    if (!bad && we) nw = st_val(ref_mem[idx], sz, a, wd);
    if (!bad && !we && rd != 0) begin
      exp_v = 1'b1; exp_d = ld_val(ref_mem[idx], sz, uns, a); exp_rd = rd;
    end else begin
      exp_v = 1'b0;
    end
    @(negedge clk);
    if (rmw) begin
      check("rmw_stall", {31'd0, stall}, 32'd0);
      check("rmw_we", {31'd0, dm_WE}, 32'd1);
      check("rmw_a", dm_A, {a[31:2], 2'b00});
      check("rmw_wd", dm_WD, nw);
      check("rmw_wbv", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    ref_mem[idx] = nw;
    check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
    check("wb_data", wb_data, exp_d);
    check("wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
    check("misalign", {31'd0, misalign}, {31'd0, bad});
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    exp_v = 1'b0; exp_d = '0; exp_rd = '0;
    @(negedge clk); @(negedge clk);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_wbd", wb_data, 32'd0);
    check("rst_wbrd", {27'd0, wb_rd}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_we", {31'd0, dm_WE}, 32'd0);
    rst = 1'b0;

    op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
    op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd5);
    check("t1_data", wb_data, 32'hDEAD_BEEF);
    op(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 5'd0);
    op(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 5'd0);
    check("t2_word", mem[8], 32'h1122_AA44);
    op(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 5'd7);
    check("t2_lb", wb_data, 32'hFFFF_FFAA);
    op(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 5'd8);
    op(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 5'd0);
    check("t3_word", mem[8], 32'h8001_AA44);
    op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd9);
    check("t3_lh", wb_data, 32'hFFFF_8001);
    op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5'd10);

    // Reset during the write half of an RMW byte store.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55; req_rd = 5'd0;
    #1 check("t4_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    #1 check("t4_we", {31'd0, dm_WE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_v = 1'b0; exp_d = '0; exp_rd = '0;
    check("t4_wbv", {31'd0, wb_valid}, 32'd0);
    check("t4_word", mem[8], 32'h8001_AA44);
    op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd3);

    op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd0);
    op(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFE_F00D, 5'd0);
    op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 5'd4);
    op(1'b1, 2'd2, 1'b0, 32'h13, 32'h1234_5678, 5'd0);
    op(1'b1, 2'd1, 1'b0, 32'h31, 32'h0000_BEEF, 5'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        exp_v = 1'b0;
        check("idle_wbv", {31'd0, wb_valid}, 32'd0);
        check("idle_mis", {31'd0, misalign}, 32'd0);
      end
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 255)), $urandom, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
